// File: rtl/ofdm_pkg.sv
// ofdm_pkg: constants, bin-type enum and the bin-classification helper shared
// by the OFDM subcarrier mapper and its pilot polarity generator.
package ofdm_pkg;

  localparam int N_FFT  = 64;
  localparam int N_DATA = 48;
  localparam int BIN_W  = 6;

  localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(N_FFT - 1);
  localparam logic [BIN_W-1:0] LAST_DATA = BIN_W'(N_DATA - 1);

  // Pilot bins and their base signs (1 = base -1)
  localparam logic [BIN_W-1:0] PILOT_BIN_0 = 6'd7;
  localparam logic [BIN_W-1:0] PILOT_BIN_1 = 6'd21;
  localparam logic [BIN_W-1:0] PILOT_BIN_2 = 6'd43;
  localparam logic [BIN_W-1:0] PILOT_BIN_3 = 6'd57;
  localparam logic             PILOT_NEG_0 = 1'b0;
  localparam logic             PILOT_NEG_1 = 1'b1;
  localparam logic             PILOT_NEG_2 = 1'b0;
  localparam logic             PILOT_NEG_3 = 1'b0;

  // Null bins: DC plus the contiguous guard band around Nyquist
  localparam logic [BIN_W-1:0] NULL_DC       = 6'd0;
  localparam logic [BIN_W-1:0] NULL_GUARD_LO = 6'd27;
  localparam logic [BIN_W-1:0] NULL_GUARD_HI = 6'd37;

  // Pilot scrambler x^7 + x^4 + 1; lfsr[6] is b7, lfsr[3] is b4
  localparam int             LFSR_W      = 7;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 7'b1111111;
  localparam int             LFSR_TAP_HI = 6;
  localparam int             LFSR_TAP_LO = 3;

  typedef enum logic [1:0] {
    BIN_NULL,
    BIN_PILOT,
    BIN_DATA
  } bin_type_t;

  function automatic bin_type_t classify_bin(input logic [BIN_W-1:0] bin);
    if (bin == NULL_DC || (bin >= NULL_GUARD_LO && bin <= NULL_GUARD_HI))
      return BIN_NULL;
    else if (bin == PILOT_BIN_0 || bin == PILOT_BIN_1 ||
             bin == PILOT_BIN_2 || bin == PILOT_BIN_3)
      return BIN_PILOT;
    else
      return BIN_DATA;
  endfunction

  function automatic logic pilot_base_neg(input logic [BIN_W-1:0] bin);
    logic neg;
    neg = 1'b0;
    if (bin == PILOT_BIN_0) neg = PILOT_NEG_0;
    if (bin == PILOT_BIN_1) neg = PILOT_NEG_1;
    if (bin == PILOT_BIN_2) neg = PILOT_NEG_2;
    if (bin == PILOT_BIN_3) neg = PILOT_NEG_3;
    return neg;
  endfunction

endpackage

// File: rtl/pilot_polarity_lfsr.sv
// pilot_polarity_lfsr: per-symbol pilot polarity (1 = invert pilots).
// With SCMAP_PILOT_POLARITY_EN defined, a 7-bit x^7+x^4+1 scrambler seeded
// to all ones supplies the polarity and steps once per advance pulse.
// Without it the scrambler is absent and polarity is fixed at +1.
module pilot_polarity_lfsr (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic polarity
);
  import ofdm_pkg::*;

`ifdef SCMAP_PILOT_POLARITY_EN
  logic [LFSR_W-1:0] lfsr;

  assign polarity = lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO];

  // Shift the feedback bit in once per completed OFDM symbol
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lfsr <= LFSR_SEED;
    else if (advance)
      lfsr <= {lfsr[LFSR_W-2:0], polarity};
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{clk, rst, advance};
  assign polarity      = 1'b0;
`endif

endmodule

// File: rtl/ofdm_subcarrier_mapper.sv
// ofdm_subcarrier_mapper: places 48 QPSK data symbols, 4 BPSK pilots and
// 12 nulls into one 64-bin IFFT input symbol, bins emitted in natural order.
// Macro SCMAP_PILOT_POLARITY_EN enables per-symbol scrambled pilot polarity;
// when undefined the pilots always carry their base sign.
//
// state  | meaning
// IDLE   | between symbols; waits for input data before starting bin 0
// ACTIVE | loading bins 0..63 into the output register
module ofdm_subcarrier_mapper #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] PILOT_AMP = 16'h5A82
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_axis_tvalid,
  input  logic [2*DATA_W-1:0] s_axis_tdata,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  input  logic                s_bit_symb_last,
  output logic                m_axis_tvalid,
  output logic [2*DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                m_bit_symb_last,
  output logic                err_symb_len
);
  import ofdm_pkg::*;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t              state;
  logic [BIN_W-1:0]    bin;
  logic [BIN_W-1:0]    data_cnt;
  logic                tlast_flag;
  bin_type_t           cur_type;
  logic                out_free;
  logic                s_hs;
  logic                load;
  logic                advance;
  logic                polarity;
  logic                pilot_neg;
  logic [DATA_W-1:0]   pilot_i;
  logic [2*DATA_W-1:0] bin_value;

  assign cur_type      = classify_bin(bin);
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == ACTIVE) && (cur_type == BIN_DATA) && out_free;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  // Data bins wait for an input symbol; nulls and pilots only need room
  assign load          = (state == ACTIVE) && out_free &&
                         ((cur_type != BIN_DATA) || s_axis_tvalid);
  assign advance       = load && (bin == LAST_BIN);

  assign pilot_neg = pilot_base_neg(bin) ^ polarity;
  assign pilot_i   = pilot_neg ? ('0 - PILOT_AMP) : PILOT_AMP;

  pilot_polarity_lfsr u_pilot_polarity (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .polarity (polarity)
  );

  // Value of the current bin: input symbol, real-valued pilot, or zero
  always_comb begin
    bin_value = '0;
    case (cur_type)
      BIN_DATA:  bin_value = s_axis_tdata;
      BIN_PILOT: bin_value = {{DATA_W{1'b0}}, pilot_i};
      default:   bin_value = '0;
    endcase
  end

  // Bin sequencing, output register, tlast latch and sticky length check
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      bin             <= '0;
      data_cnt        <= '0;
      tlast_flag      <= 1'b0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tlast    <= 1'b0;
      m_bit_symb_last <= 1'b0;
      err_symb_len    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (s_axis_tvalid) begin
          state <= ACTIVE;
          bin   <= '0;
        end
      end else if (load) begin
        if (s_hs)
          data_cnt <= data_cnt + 6'd1;
        if (bin == LAST_BIN) begin
          state    <= IDLE;
          bin      <= '0;
          data_cnt <= '0;
        end else begin
          bin <= bin + 6'd1;
        end
      end

      if (advance)
        tlast_flag <= 1'b0;
      else if (s_hs && s_axis_tlast)
        tlast_flag <= 1'b1;

      if (load) begin
        m_axis_tvalid   <= 1'b1;
        m_axis_tdata    <= bin_value;
        m_axis_tlast    <= (bin == LAST_BIN) && (tlast_flag || (s_hs && s_axis_tlast));
        m_bit_symb_last <= (bin == LAST_BIN);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      // Upstream's end-of-symbol marker must line up with our own count
      if (s_hs && ((data_cnt == LAST_DATA) != s_bit_symb_last))
        err_symb_len <= 1'b1;
    end
  end

endmodule
